dmem_ctrl: RTL

Parametrised successor to the core's load/store data memory. Owns an internal word array with byte-enable writes and a registered read port, and decodes RV32 load/store width/sign from funct3. Adds a valid/ready request and response handshake, range/encoding error reporting, and optional misaligned-access splitting via a small FSM. Sits in the MEM stage between the ALU-result pipeline register and writeback.

---
 rtl/dmem_if.sv | 26 ++
 rtl/dmem_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Request/response bus of the MEM-stage data memory controller.
//   master: drives req_* (pipeline side), receives req_ready and rsp_*
//   slave : dmem_ctrl side
interface dmem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// RV32 load/store data memory with valid/ready handshake.
//   clk, rst : clock (rising edge), async active-high reset
//   bus      : dmem_if.slave -- request (we/addr/funct3/wdata) and one-cycle
//              response pulse (rdata/err); no response backpressure.
// Aligned or intra-word accesses respond after 1 cycle. Word-crossing
// accesses (SPLIT_MISALIGN=1) take an extra SPLIT cycle for the upper word.
module dmem_ctrl #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 12,
  parameter bit SPLIT_MISALIGN = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);
  localparam int NB        = DATA_W / 8;
  localparam int OFF_W     = $clog2(NB);
  localparam int WA_W      = $clog2(DEPTH);
  localparam int MEM_BYTES = DEPTH * NB;

  typedef enum logic {S_IDLE, S_SPLIT} state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  logic              r_ready, r_rsp_valid, r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  // request context held across the SPLIT cycle
  logic              r_we;
  logic [2:0]        r_f3;
  logic [OFF_W-1:0]  r_off;
  logic [WA_W-1:0]   r_idx_hi;
  logic [DATA_W-1:0] r_lo_word;
  logic [NB-1:0]     r_be_hi;
  logic [DATA_W-1:0] r_wd_hi;

  logic              w_acc, w_legal, w_oor, w_misal, w_cross, w_err;
  logic [2:0]        w_size;
  logic [3:0]        w_smask;
  logic [ADDR_W:0]   w_last;
  logic [OFF_W-1:0]  w_off;
  logic [WA_W-1:0]   w_idx;
  logic [2*NB-1:0]   w_be;
  logic [2*DATA_W-1:0] w_wwin;
  logic [DATA_W-1:0] w_ld_raw, w_sp_raw;

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

  // memory is gated off while reset is held even though ready reads 1
  assign w_acc = bus.req_valid && r_ready && !rst;

  always_comb begin
    w_legal = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !bus.req_we;
      default:                w_legal = 1'b0;
    endcase
    w_size  = 3'd4;
    w_smask = 4'b1111;
    case (bus.req_funct3[1:0])
      2'b00:   begin w_size = 3'd1; w_smask = 4'b0001; end
      2'b01:   begin w_size = 3'd2; w_smask = 4'b0011; end
      default: begin w_size = 3'd4; w_smask = 4'b1111; end
    endcase
  end

  // last byte touched, one bit wider than the address so there is no wrap
  assign w_last  = {1'b0, bus.req_addr} + {{(ADDR_W-2){1'b0}}, w_size} - (ADDR_W+1)'(1);
  assign w_oor   = w_last >= (ADDR_W+1)'(MEM_BYTES);
  assign w_misal = (bus.req_addr[2:0] & (w_size - 3'd1)) != 3'd0;
  assign w_off   = bus.req_addr[OFF_W-1:0];
  assign w_cross = ({1'b0, w_off} + (OFF_W+1)'(w_size)) > (OFF_W+1)'(NB);
  assign w_err   = !w_legal || w_oor || (w_misal && !SPLIT_MISALIGN);
  assign w_idx   = bus.req_addr[OFF_W +: WA_W];

  // two-word window: low half hits word N, high half word N+1
  assign w_be   = (2*NB)'(w_smask) << w_off;
  assign w_wwin = (2*DATA_W)'(bus.req_wdata) << {w_off, 3'b000};

  assign w_ld_raw = r_mem[w_idx] >> {w_off, 3'b000};
  assign w_sp_raw = DATA_W'({r_mem[r_idx_hi], r_lo_word} >> {r_off, 3'b000});

  function automatic logic [DATA_W-1:0] f_ext(input logic [DATA_W-1:0] raw,
                                              input logic [2:0] f3);
    logic [DATA_W-1:0] v;
    v = '0;
    case (f3)
      3'b000:  begin v = {DATA_W{raw[7]}};  v[7:0]  = raw[7:0];  end
      3'b001:  begin v = {DATA_W{raw[15]}}; v[15:0] = raw[15:0]; end
      3'b100:  v[7:0]  = raw[7:0];
      3'b101:  v[15:0] = raw[15:0];
      default: v[31:0] = raw[31:0];
    endcase
    return v;
  endfunction

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (w_acc && bus.req_we && !w_err && w_be[b])
        r_mem[w_idx][b*8 +: 8] <= w_wwin[b*8 +: 8];
      if (r_state == S_SPLIT && r_we && r_be_hi[b])
        r_mem[r_idx_hi][b*8 +: 8] <= r_wd_hi[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_we        <= 1'b0;
      r_f3        <= 3'b000;
      r_off       <= '0;
      r_idx_hi    <= '0;
      r_lo_word   <= '0;
      r_be_hi     <= '0;
      r_wd_hi     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
          if (w_acc) begin
            if (w_err) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else if (w_cross) begin
              // only reachable with SPLIT_MISALIGN=1; low word already done
              r_state   <= S_SPLIT;
              r_ready   <= 1'b0;
              r_we      <= bus.req_we;
              r_f3      <= bus.req_funct3;
              r_off     <= w_off;
              r_idx_hi  <= w_idx + WA_W'(1);
              r_lo_word <= r_mem[w_idx];
              r_be_hi   <= w_be[2*NB-1:NB];
              r_wd_hi   <= w_wwin[2*DATA_W-1:DATA_W];
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= bus.req_we ? '0 : f_ext(w_ld_raw, bus.req_funct3);
            end
          end
        end
        S_SPLIT: begin
          r_state     <= S_IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= r_we ? '0 : f_ext(w_sp_raw, r_f3);
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
